// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM states and counter sizing for the serial adder/subtractor
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int cyc);
    return cyc > 1 ? $clog2(cyc) : 1;
  endfunction
endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: request/result bundle between a requester and the serial adder
interface addsub_serial_if #(parameter int WIDTH = 8);
  logic start;
  logic select;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic carry_out;
  logic overflow;
  modport master (output start, select, A, B, input busy, done, sum, carry_out, overflow);
  modport slave (input start, select, A, B, output busy, done, sum, carry_out, overflow);
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple adder exposing the carry into its MSB
module addsub_digit #(parameter int DIGIT = 1) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial A+B / A-B, DIGIT bits per clock, LSB digit first
module addsub_serial import addsub_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic reset,
  addsub_serial_if.slave bus
);
  localparam int CYC = WIDTH / DIGIT;
  localparam int CW = cnt_w(CYC);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [DIGIT-1:0] ds;
  logic [CW-1:0] cnt;
  logic c, dco, dcm, last;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a(a_sh[DIGIT-1:0]), .b(b_sh[DIGIT-1:0]), .cin(c), .s(ds), .cout(dco), .cmsb(dcm)
  );
  assign last = state == RUN && cnt == CW'(CYC - 1);
  assign r_cat = {ds, r_sh};
  assign r_next = r_cat[WIDTH+DIGIT-1:DIGIT];
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // subtraction is A + ~B + 1: the +1 rides in as the seeded carry
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      bus.sum <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sh <= bus.A;
      b_sh <= bus.select ? ~bus.B : bus.B;
      c <= bus.select;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      r_sh <= r_next;
      c <= dco;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.sum <= r_next;
        bus.carry_out <= dco;
        bus.overflow <= dcm ^ dco;
      end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: table-driven checks of the serial adder plus latency, handshake and reset sequences
module tb_addsub_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int lat;
  addsub_serial_if #(.WIDTH(4)) i4 ();
  addsub_serial_if #(.WIDTH(8)) i8 ();
  addsub_serial #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .reset(reset), .bus(i4.slave));
  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  vec_t v4[9];
  vec_t v8[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input bit w8, input logic sel, input logic [7:0] a, input logic [7:0] b, output int l);
    @(negedge clk);
    if (w8) begin
      i8.start = 1'b1; i8.select = sel; i8.A = a; i8.B = b;
    end else begin
      i4.start = 1'b1; i4.select = sel; i4.A = a[3:0]; i4.B = b[3:0];
    end
    @(posedge clk); #1;
    i4.start = 1'b0;
    i8.start = 1'b0;
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (w8 ? i8.done : i4.done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    v4[0] = '{1'b0, 8'd3,  8'd10, 8'd13, 1'b0, 1'b0};
    v4[1] = '{1'b0, 8'd11, 8'd10, 8'd5,  1'b1, 1'b1};
    v4[2] = '{1'b0, 8'd15, 8'd15, 8'd14, 1'b1, 1'b0};
    v4[3] = '{1'b1, 8'd1,  8'd1,  8'd0,  1'b1, 1'b0};
    v4[4] = '{1'b1, 8'd3,  8'd10, 8'd9,  1'b0, 1'b1};
    v4[5] = '{1'b1, 8'd11, 8'd10, 8'd1,  1'b1, 1'b0};
    v4[6] = '{1'b0, 8'd7,  8'd1,  8'd8,  1'b0, 1'b1};
    v4[7] = '{1'b1, 8'd0,  8'd1,  8'd15, 1'b0, 1'b0};
    v4[8] = '{1'b1, 8'd8,  8'd1,  8'd7,  1'b1, 1'b1};
    v8[0] = '{1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    v8[1] = '{1'b0, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1};
    v8[2] = '{1'b1, 8'd50,  8'd100, 8'd206, 1'b0, 1'b0};
    i4.start = 1'b0; i4.select = 1'b0; i4.A = '0; i4.B = '0;
    i8.start = 1'b0; i8.select = 1'b0; i8.A = '0; i8.B = '0;
    #1;
    chk("reset_busy", i4.busy, 0);
    chk("reset_done", i4.done, 0);
    chk("reset_sum", i4.sum, 0);
    chk("reset_co_ov", {i4.carry_out, i4.overflow}, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    foreach (v4[n]) begin
      do_op(1'b0, v4[n].sel, v4[n].a, v4[n].b, lat);
      chk($sformatf("w4_lat%0d", n), lat, 4);
      chk($sformatf("w4_sum%0d", n), i4.sum, v4[n].s[3:0]);
      chk($sformatf("w4_co%0d", n), i4.carry_out, v4[n].co);
      chk($sformatf("w4_ov%0d", n), i4.overflow, v4[n].ov);
      chk($sformatf("w4_busy_done%0d", n), i4.busy, 1);
      @(posedge clk); #1;
      chk($sformatf("w4_done_pulse%0d", n), i4.done, 0);
      chk($sformatf("w4_idle%0d", n), i4.busy, 0);
    end
    foreach (v8[n]) begin
      do_op(1'b1, v8[n].sel, v8[n].a, v8[n].b, lat);
      chk($sformatf("w8_lat%0d", n), lat, 2);
      chk($sformatf("w8_sum%0d", n), i8.sum, v8[n].s);
      chk($sformatf("w8_co_ov%0d", n), {i8.carry_out, i8.overflow}, {v8[n].co, v8[n].ov});
      chk($sformatf("w8_busy_done%0d", n), i8.busy, 1);
      @(posedge clk); #1;
      chk($sformatf("w8_idle%0d", n), {i8.busy, i8.done}, 0);
    end
    // start held high; operands change mid-RUN; sum holds previous result during RUN
    @(negedge clk);
    i4.start = 1'b1; i4.select = 1'b0; i4.A = 4'd3; i4.B = 4'd10;
    @(posedge clk); #1;
    chk("held_busy_k", i4.busy, 1);
    i4.A = 4'd15; i4.B = 4'd15;
    @(posedge clk); #1;
    chk("held_sum_hold", i4.sum, 7);
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i4.done) begin lat = i; break; end
    end
    chk("held_lat", lat, 4);
    chk("held_sum1", i4.sum, 13);
    @(posedge clk); #1;
    chk("held_idle", {i4.busy, i4.done}, 0);
    @(posedge clk); #1;
    chk("held_restart", i4.busy, 1);
    i4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i4.done) begin lat = i; break; end
    end
    chk("held_lat2", lat, 4);
    chk("held_sum2", i4.sum, 14);
    chk("held_co2", i4.carry_out, 1);
    // asynchronous reset during RUN cycle 2 aborts without a done pulse
    @(negedge clk);
    i4.start = 1'b1; i4.select = 1'b0; i4.A = 4'd11; i4.B = 4'd10;
    @(posedge clk); #1;
    i4.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_sum", i4.sum, 0);
    chk("abort_busy_done", {i4.busy, i4.done}, 0);
    chk("abort_co", i4.carry_out, 0);
    #3 reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i4.done || i4.busy) lat = i;
    end
    chk("abort_no_done", lat, 0);
    do_op(1'b0, 1'b1, 8'd3, 8'd10, lat);
    chk("after_abort_lat", lat, 4);
    chk("after_abort_sum", i4.sum, 9);
    chk("after_abort_ov", i4.overflow, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; must be a multiple of DIGIT.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per clock; CYC = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a new operation.
REQ-006 SHALL have port select  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 SHALL have port A  input  WIDTH  first operand; sampled with start.
REQ-008 SHALL have port B  input  WIDTH  second operand; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 SHALL have port carry_out  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned).
REQ-013 SHALL have port overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after CYC digit cycles, DONE->IDLE unconditionally.
REQ-015 SHALL, on the edge that samples start=1 in IDLE (edge k), capture A, select, and B (inverted when select=1) into shift registers; the carry is seeded with select.
REQ-016 SHALL process DIGIT LSBs per RUN cycle, LSB digit first, with the carry propagated between digits in a register.
REQ-017 SHALL update sum, carry_out and overflow on edge k+CYC and assert done for exactly the cycle following that edge.
REQ-018 SHALL hold sum, carry_out and overflow at their last completed values between operations and during RUN.
REQ-019 SHALL compute overflow as the carry into the MSB XOR the carry out of the MSB.
REQ-020 SHALL ignore start while busy=1, including in the DONE cycle; inputs are not re-sampled.
REQ-021 SHALL keep busy low in IDLE, so that a new start is accepted on the first IDLE cycle after done.

Reset
REQ-022 SHALL, on reset, immediately force state IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, and clear the internal shift registers and counter.
REQ-023 SHALL abort an operation in progress when reset is asserted mid-operation; no done pulse is produced for the aborted operation.

Structure
REQ-024 SHALL place the FSM state encodings in shared package addsub_pkg.
REQ-025 SHALL place the CYC-width counter sizing function in addsub_pkg.
REQ-026 SHALL use one sub-module addsub_digit: a combinational DIGIT-bit ripple adder with cin, cout, and carry-into-MSB outputs.

Verification
REQ-027 SHALL cover add with WIDTH=4, DIGIT=1: 3+10 -> sum=13, carry_out=0, overflow=0; 11+10 -> sum=5, carry_out=1, overflow=1; 15+15 -> sum=14, carry_out=1, overflow=0.
REQ-028 SHALL cover subtract with WIDTH=4, DIGIT=1: 1-1 -> sum=0, carry_out=1, overflow=0; 3-10 -> sum=9, carry_out=0, overflow=1; 11-10 -> sum=1, carry_out=1, overflow=0.
REQ-029 SHALL cover latency and handshake with WIDTH=8, DIGIT=4: start at edge k -> done high only in the cycle after edge k+2, and busy high from k to k+3; with WIDTH=4, DIGIT=1, done follows edge k+4.
REQ-030 SHALL cover start held high through an operation -> operands changed mid-RUN are ignored, and the second operation starts on the first IDLE edge after done.
REQ-031 SHALL cover reset asserted at RUN cycle 2 -> outputs zero asynchronously, no done pulse, and the next start completes normally.
